id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: instructionFetchReg  in  64  IF/ID register, [63:32] instruction, [31:0] PC+4.
REQ-004 SHALL have: wbWriteEn  in  1 / wbWriteReg  in  5 / wbWriteData  in  32  writeback port.
REQ-005 SHALL have: exMemRegWrite  in  1 / exMemWriteReg  in  5  EX/MEM destination, for branch hazards.
REQ-006 SHALL have: branchResult  out  1 / branchAddrs  out  32  redirect to IF.
REQ-007 SHALL have: regStall  out  1 / muxStall  out  1  IF/ID hold and PC hold.
REQ-008 SHALL have registered ID/EX outputs: idExCtrl 8 {regDst,aluSrc,memToReg,regWrite,memRead,memWrite,aluOp[1:0]}, idExPc4 32, idExRsData 32, idExRtData 32, idExImm 32, idExRt 5, idExRd 5.

Function
REQ-009 SHALL contain a 32x32 register file; r0 always reads 0; written at posedge when wbWriteEn and wbWriteReg!=0.
REQ-010 SHALL bypass same-cycle WB write to read ports (read address == wbWriteReg, wbWriteEn, nonzero -> wbWriteData).
REQ-011 SHALL decode opcodes: 000000 R (10000010), 100011 lw (01110000), 101011 sw (01000100), 000100 beq (00000001), 001000 addi (01010000), 000010 j (00000000); any other opcode -> ctrl 0.
REQ-012 SHALL sign-extend instr[15:0] to idExImm.
REQ-013 SHALL detect load-use: idExCtrl.memRead, idExRt!=0, idExRt equals rs, or equals rt for R/beq/bne/sw -> stall.
REQ-014 SHALL detect branch-operand hazard: beq/bne whose rs or rt (nonzero) matches ID/EX destination (regDst?idExRd:idExRt) with idExCtrl.regWrite, or matches exMemWriteReg with exMemRegWrite -> stall.
REQ-015 SHALL drive regStall=muxStall=1 combinationally during any stall, else 0.
REQ-016 SHALL load ID/EX with ctrl=0 (bubble) on stall; other ID/EX fields don't-care but defined.
REQ-017 SHALL assert branchResult combinationally when not stalled and (beq with rsData==rtData, bne with rsData!=rtData, or j).
REQ-018 SHALL set branchAddrs = PC4 + (imm<<2) for beq/bne, {PC4[31:28],instr[25:0],2'b00} for j, 0 otherwise.
REQ-019 SHALL pass branch and jump instructions into ID/EX with their ctrl (no register or memory write).
REQ-020 SHALL treat an all-zero instructionFetchReg (IF flush) as a NOP producing ctrl=0.
REQ-021 Stall SHALL dominate: branchResult=0 in any stalled cycle; the branch resolves in the first non-stalled cycle.
REQ-022 ID/EX SHALL update every posedge (no hold input); latency IF/ID -> ID/EX one cycle.

Reset
REQ-023 SHALL on rst_n=0 asynchronously clear all ID/EX outputs and all 32 registers to 0.
REQ-024 Combinational outputs SHALL reflect cleared ID/EX during reset; a stall cannot originate from ID/EX state while in reset.
REQ-025 Reset deasserted mid-stall SHALL resume with no stall from cleared ID/EX.

Configuration
REQ-026 SHALL compile bne support only when ID_BNE_EN is defined: with it, opcode 000101 decodes as ctrl 00000001 and branches on inequality; without it, 000101 is unknown -> ctrl 0, never branches, never stalls.

Verification
REQ-027 Write r5=7, r6=7 via WB; feed beq r5,r6,+3 with PC4=0x40 -> branchResult=1, branchAddrs=0x4C same cycle.
REQ-028 lw r2,0(r1) then add r3,r2,r4 -> second cycle regStall=muxStall=1, next idExCtrl=0, third cycle add issued with ctrl 10000010.
REQ-029 addi r8,r0,1 followed by beq r8,r0 -> one stall cycle (ID/EX), second stall (exMemWriteReg=8), branchResult evaluated third cycle.
REQ-030 WB writes r9=0xDEAD same cycle ID reads r9 -> idExRsData=0x0000DEAD next edge; write to r0 -> r0 reads 0.
REQ-031 j 0x0000100 with PC4=0x30000004 -> branchAddrs=0x30000400; opcode 000101 with/without ID_BNE_EN -> taken when unequal / ctrl 0 and no branch.
REQ-032 Assert rst_n=0 mid-stall between edges -> outputs 0 immediately, regStall=0 after release.

Source files
------------

// File: rtl/id_stage_if.sv
// Bus between the ID stage and its neighbours: IF/ID input, writeback and EX/MEM
// hazard inputs, branch redirect, stall controls and the registered ID/EX fields.
interface id_stage_if;
    logic [63:0] instructionFetchReg;
    logic        wbWriteEn;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        exMemRegWrite;
    logic [4:0]  exMemWriteReg;
    logic        branchResult;
    logic [31:0] branchAddrs;
    logic        regStall;
    logic        muxStall;
    logic [7:0]  idExCtrl;
    logic [31:0] idExPc4;
    logic [31:0] idExRsData;
    logic [31:0] idExRtData;
    logic [31:0] idExImm;
    logic [4:0]  idExRt;
    logic [4:0]  idExRd;

    modport master (
        output instructionFetchReg, wbWriteEn, wbWriteReg, wbWriteData,
               exMemRegWrite, exMemWriteReg,
        input  branchResult, branchAddrs, regStall, muxStall,
               idExCtrl, idExPc4, idExRsData, idExRtData, idExImm, idExRt, idExRd
    );

    modport slave (
        input  instructionFetchReg, wbWriteEn, wbWriteReg, wbWriteData,
               exMemRegWrite, exMemWriteReg,
        output branchResult, branchAddrs, regStall, muxStall,
               idExCtrl, idExPc4, idExRsData, idExRtData, idExImm, idExRt, idExRd
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: register file, control decode, hazard stalls, early branch
// resolution and the ID/EX pipeline register. Define ID_BNE_EN to add bne support.
module id_stage (
    input  logic      clk,
    input  logic      rst_n,
    id_stage_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef ID_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    logic [31:0] regs [32];
    logic [31:0] instr, pc4, imm, rs_data, rt_data;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, ex_dest;
    logic [7:0]  ctrl;
    logic        flush, is_beq, is_bne, is_j, uses_rs, uses_rt;
    logic        ex_load, load_use, branch_hazard, stall, is_branch;

    assign instr  = bus.instructionFetchReg[63:32];
    assign pc4    = bus.instructionFetchReg[31:0];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = {{16{instr[15]}}, instr[15:0]};
    assign flush  = (bus.instructionFetchReg == 64'd0);

    always_comb begin
        ctrl    = 8'd0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        if (!flush) begin
            case (opcode)
                OP_R:    begin ctrl = 8'b10000010; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_LW:   begin ctrl = 8'b01110000; uses_rs = 1'b1; end
                OP_SW:   begin ctrl = 8'b01000100; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_BEQ:  begin ctrl = 8'b00000001; is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_ADDI: begin ctrl = 8'b01010000; uses_rs = 1'b1; end
                OP_J:    begin is_j = 1'b1; end
`ifdef ID_BNE_EN
                OP_BNE:  begin ctrl = 8'b00000001; is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    // Writeback in the same cycle is forwarded so ID never reads a stale value.
    assign rs_data = (rs == 5'd0) ? 32'd0 :
                     (bus.wbWriteEn && bus.wbWriteReg == rs) ? bus.wbWriteData : regs[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 :
                     (bus.wbWriteEn && bus.wbWriteReg == rt) ? bus.wbWriteData : regs[rt];

    // The lw encoding carries memToReg without memRead, so either bit marks a load.
    assign ex_load  = bus.idExCtrl[3] | bus.idExCtrl[5];
    assign ex_dest  = bus.idExCtrl[7] ? bus.idExRd : bus.idExRt;
    assign is_branch = is_beq | is_bne;

    assign load_use = ex_load && (bus.idExRt != 5'd0) &&
                      ((uses_rs && bus.idExRt == rs) || (uses_rt && bus.idExRt == rt));

    assign branch_hazard = is_branch && (
        ((rs != 5'd0) && ((bus.idExCtrl[4] && ex_dest == rs) ||
                          (bus.exMemRegWrite && bus.exMemWriteReg == rs))) ||
        ((rt != 5'd0) && ((bus.idExCtrl[4] && ex_dest == rt) ||
                          (bus.exMemRegWrite && bus.exMemWriteReg == rt))));

    assign stall        = load_use | branch_hazard;
    assign bus.regStall = stall;
    assign bus.muxStall = stall;

    assign bus.branchResult = !stall && ((is_beq && rs_data == rt_data) ||
                                         (is_bne && rs_data != rt_data) || is_j);
    assign bus.branchAddrs  = is_branch ? pc4 + {imm[29:0], 2'b00} :
                              is_j      ? {pc4[31:28], instr[25:0], 2'b00} : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (bus.wbWriteEn && bus.wbWriteReg != 5'd0) begin
            regs[bus.wbWriteReg] <= bus.wbWriteData;
        end
    end

    // A stall inserts a bubble by zeroing control; the data fields still load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.idExCtrl   <= 8'd0;
            bus.idExPc4    <= 32'd0;
            bus.idExRsData <= 32'd0;
            bus.idExRtData <= 32'd0;
            bus.idExImm    <= 32'd0;
            bus.idExRt     <= 5'd0;
            bus.idExRd     <= 5'd0;
        end else begin
            bus.idExCtrl   <= stall ? 8'd0 : ctrl;
            bus.idExPc4    <= pc4;
            bus.idExRsData <= rs_data;
            bus.idExRtData <= rt_data;
            bus.idExImm    <= imm;
            bus.idExRt     <= rt;
            bus.idExRd     <= rd;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a vector table of single-cycle decode cases plus
// hand-written multi-cycle sequences for stalls, bypass and reset.
module tb_id_stage;
    logic clk;
    logic rst_n;
    int   n_vectors;
    int   n_miscompares;

    id_stage_if bus_if ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        exm_en;
        logic [4:0]  exm_reg;
        logic        exp_stall;
        logic        exp_br;
        logic [31:0] exp_addr;
        logic [7:0]  exp_ctrl;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc4,
                                  input logic exm_en, input logic [4:0] exm_reg);
        bus_if.instructionFetchReg = {instr, pc4};
        bus_if.exMemRegWrite       = exm_en;
        bus_if.exMemWriteReg       = exm_reg;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        apply_stimulus(32'd0, 32'd0, 1'b0, 5'd0);
        bus_if.wbWriteEn   = 1'b1;
        bus_if.wbWriteReg  = r;
        bus_if.wbWriteData = d;
        @(posedge clk); #1;
        bus_if.wbWriteEn = 1'b0;
    endtask

    task automatic check_comb(input string tag, input logic stall, input logic br,
                              input logic [31:0] addr);
        check_output({tag, " regStall"}, {31'd0, bus_if.regStall}, {31'd0, stall});
        check_output({tag, " muxStall"}, {31'd0, bus_if.muxStall}, {31'd0, stall});
        check_output({tag, " branchResult"}, {31'd0, bus_if.branchResult}, {31'd0, br});
        check_output({tag, " branchAddrs"}, bus_if.branchAddrs, addr);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n = 1'b0;
        bus_if.wbWriteEn   = 1'b0;
        bus_if.wbWriteReg  = 5'd0;
        bus_if.wbWriteData = 32'd0;
        apply_stimulus(32'd0, 32'd0, 1'b0, 5'd0);

        vecs[0]  = '{i_type(6'b000100, 5'd5, 5'd6, 16'd3), 32'h40, 1'b0, 5'd0,
                     1'b0, 1'b1, 32'h4C, 8'b00000001, 32'd7, 32'd7, 32'd3};
        vecs[1]  = '{i_type(6'b000100, 5'd10, 5'd11, 16'hFFFE), 32'h100, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'hF8, 8'b00000001, 32'd5, 32'd6, 32'hFFFFFFFE};
        vecs[2]  = '{{6'b000010, 26'h0000100}, 32'h30000004, 1'b0, 5'd0,
                     1'b0, 1'b1, 32'h30000400, 8'b00000000, 32'd0, 32'd0, 32'h100};
        vecs[3]  = '{i_type(6'b001000, 5'd4, 5'd7, 16'hFFFF), 32'h44, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'd0, 8'b01010000, 32'd3, 32'd0, 32'hFFFFFFFF};
        vecs[4]  = '{i_type(6'b101011, 5'd1, 5'd5, 16'd8), 32'h48, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'd0, 8'b01000100, 32'h100, 32'd7, 32'd8};
        vecs[5]  = '{i_type(6'b111111, 5'd5, 5'd6, 16'h1234), 32'h4C, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'd0, 8'b00000000, 32'd7, 32'd7, 32'h1234};
        vecs[6]  = '{32'd0, 32'd0, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'd0, 8'b00000000, 32'd0, 32'd0, 32'd0};
        vecs[7]  = '{r_type(5'd5, 5'd6, 5'd3), 32'h50, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'd0, 8'b10000010, 32'd7, 32'd7, 32'h1820};
`ifdef ID_BNE_EN
        vecs[8]  = '{i_type(6'b000101, 5'd10, 5'd11, 16'd4), 32'h200, 1'b0, 5'd0,
                     1'b0, 1'b1, 32'h210, 8'b00000001, 32'd5, 32'd6, 32'd4};
`else
        vecs[8]  = '{i_type(6'b000101, 5'd10, 5'd11, 16'd4), 32'h200, 1'b0, 5'd0,
                     1'b0, 1'b0, 32'd0, 8'b00000000, 32'd5, 32'd6, 32'd4};
`endif
        vecs[9]  = '{i_type(6'b000100, 5'd5, 5'd6, 16'd1), 32'h80, 1'b1, 5'd6,
                     1'b1, 1'b0, 32'h84, 8'b00000000, 32'd7, 32'd7, 32'd1};
        vecs[10] = '{i_type(6'b000100, 5'd5, 5'd6, 16'd1), 32'h80, 1'b0, 5'd0,
                     1'b0, 1'b1, 32'h84, 8'b00000001, 32'd7, 32'd7, 32'd1};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset idExCtrl", {24'd0, bus_if.idExCtrl}, 32'd0);
        check_output("reset idExPc4", bus_if.idExPc4, 32'd0);
        check_comb("reset", 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        wb_write(5'd5, 32'd7);
        wb_write(5'd6, 32'd7);
        wb_write(5'd1, 32'h100);
        wb_write(5'd4, 32'd3);
        wb_write(5'd10, 32'd5);
        wb_write(5'd11, 32'd6);

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            apply_stimulus(vecs[i].instr, vecs[i].pc4, vecs[i].exm_en, vecs[i].exm_reg);
            #2;
            check_comb(tag, vecs[i].exp_stall, vecs[i].exp_br, vecs[i].exp_addr);
            @(posedge clk); #1;
            check_output({tag, " idExCtrl"}, {24'd0, bus_if.idExCtrl}, {24'd0, vecs[i].exp_ctrl});
            check_output({tag, " idExRsData"}, bus_if.idExRsData, vecs[i].exp_rs);
            check_output({tag, " idExRtData"}, bus_if.idExRtData, vecs[i].exp_rt);
            check_output({tag, " idExImm"}, bus_if.idExImm, vecs[i].exp_imm);
            check_output({tag, " idExPc4"}, bus_if.idExPc4, vecs[i].pc4);
            if (!vecs[i].exp_stall) begin
                check_output({tag, " idExRt"}, {27'd0, bus_if.idExRt}, {27'd0, vecs[i].instr[20:16]});
                check_output({tag, " idExRd"}, {27'd0, bus_if.idExRd}, {27'd0, vecs[i].instr[15:11]});
            end
        end

        // load-use: lw r2,0(r1) then add r3,r2,r4
        apply_stimulus(i_type(6'b100011, 5'd1, 5'd2, 16'd0), 32'h60, 1'b0, 5'd0);
        #2 check_comb("lw", 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        check_output("lw idExCtrl", {24'd0, bus_if.idExCtrl}, 32'b01110000);
        apply_stimulus(r_type(5'd2, 5'd4, 5'd3), 32'h64, 1'b0, 5'd0);
        #2 check_comb("loaduse", 1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        check_output("loaduse bubble", {24'd0, bus_if.idExCtrl}, 32'd0);
        #1 check_comb("loaduse resume", 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        check_output("loaduse issue", {24'd0, bus_if.idExCtrl}, 32'b10000010);
        check_output("loaduse rt", bus_if.idExRtData, 32'd3);

        // branch operand hazard: addi r8,r0,1 then beq r8,r0,+2
        apply_stimulus(i_type(6'b001000, 5'd0, 5'd8, 16'd1), 32'h5C, 1'b0, 5'd0);
        @(posedge clk); #1;
        apply_stimulus(i_type(6'b000100, 5'd8, 5'd0, 16'd2), 32'h60, 1'b0, 5'd0);
        #2 check_comb("brhaz idex", 1'b1, 1'b0, 32'h68);
        @(posedge clk); #1;
        check_output("brhaz bubble", {24'd0, bus_if.idExCtrl}, 32'd0);
        apply_stimulus(i_type(6'b000100, 5'd8, 5'd0, 16'd2), 32'h60, 1'b1, 5'd8);
        #2 check_comb("brhaz exmem", 1'b1, 1'b0, 32'h68);
        @(posedge clk); #1;
        apply_stimulus(i_type(6'b000100, 5'd8, 5'd0, 16'd2), 32'h60, 1'b0, 5'd0);
        #2 check_comb("brhaz resolve", 1'b0, 1'b1, 32'h68);
        @(posedge clk); #1;
        check_output("brhaz issue", {24'd0, bus_if.idExCtrl}, 32'b00000001);

        // writeback bypass and r0 protection
        apply_stimulus(i_type(6'b001000, 5'd9, 5'd12, 16'd0), 32'h70, 1'b0, 5'd0);
        bus_if.wbWriteEn = 1'b1; bus_if.wbWriteReg = 5'd9; bus_if.wbWriteData = 32'hDEAD;
        @(posedge clk); #1;
        check_output("bypass r9", bus_if.idExRsData, 32'h0000DEAD);
        apply_stimulus(i_type(6'b001000, 5'd0, 5'd13, 16'd0), 32'h74, 1'b0, 5'd0);
        bus_if.wbWriteReg = 5'd0; bus_if.wbWriteData = 32'h55;
        @(posedge clk); #1;
        bus_if.wbWriteEn = 1'b0;
        check_output("r0 bypass", bus_if.idExRsData, 32'd0);
        apply_stimulus(r_type(5'd9, 5'd0, 5'd14), 32'h78, 1'b0, 5'd0);
        @(posedge clk); #1;
        check_output("r9 stored", bus_if.idExRsData, 32'h0000DEAD);
        check_output("r0 stored", bus_if.idExRtData, 32'd0);

        // reset asserted in the middle of a load-use stall
        apply_stimulus(i_type(6'b100011, 5'd1, 5'd2, 16'd0), 32'h80, 1'b0, 5'd0);
        @(posedge clk); #1;
        apply_stimulus(r_type(5'd2, 5'd4, 5'd3), 32'h84, 1'b0, 5'd0);
        #2 check_comb("prereset", 1'b1, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_output("midrst idExCtrl", {24'd0, bus_if.idExCtrl}, 32'd0);
        check_output("midrst idExPc4", bus_if.idExPc4, 32'd0);
        check_comb("midrst", 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check_comb("postrst", 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        check_output("postrst idExCtrl", {24'd0, bus_if.idExCtrl}, 32'b10000010);
        check_output("postrst r4 cleared", bus_if.idExRtData, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
